tcdm_port_arbiter: RTL

- Round-robin arbiter that shares one TCDM-style memory port (req/gnt request phase, r_valid response phase) among N_REQ requesters.
- Typical use: merging the core data port and an accelerator side-port onto one dummy-memory or TCDM port.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.

---
 rtl/tcdm_port_arbiter_if.sv | 35 +++
 rtl/tcdm_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tcdm_port_arbiter_if.sv
// Bus bundle for tcdm_port_arbiter: requester-side and memory-side TCDM signals.
// The slave modport is the arbiter's view; master is the environment driving it.
interface tcdm_port_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*AW-1:0]     add_i;
  logic [N_REQ-1:0]        wen_i;
  logic [N_REQ*DW/8-1:0]   be_i;
  logic [N_REQ*DW-1:0]     data_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [DW-1:0]           r_data_o;
  logic [N_REQ-1:0]        r_valid_o;
  logic                    req_o;
  logic [AW-1:0]           add_o;
  logic                    wen_o;
  logic [DW/8-1:0]         be_o;
  logic [DW-1:0]           data_o;
  logic                    gnt_i;
  logic [DW-1:0]           r_data_i;
  logic                    r_valid_i;
  logic                    err_o;

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i, gnt_i, r_data_i, r_valid_i,
    output gnt_o, r_data_o, r_valid_o, req_o, add_o, wen_o, be_o, data_o, err_o
  );

  modport master (
    output req_i, add_i, wen_i, be_i, data_i, gnt_i, r_data_i, r_valid_i,
    input  gnt_o, r_data_o, r_valid_o, req_o, add_o, wen_o, be_o, data_o, err_o
  );
endinterface

// File: rtl/tcdm_port_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ requesters, with in-order response routing.
// Define TCDM_ARB_PERF_CNT_EN to add per-requester grant counters and a stall counter.
module tcdm_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tcdm_port_arbiter_if.slave    bus
`ifdef TCDM_ARB_PERF_CNT_EN
  ,
  output logic [N_REQ*32-1:0]   cnt_gnt_o,
  output logic [31:0]           cnt_stall_o
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int BW = DW / 8;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] winner, sel, head;
  logic [IW:0]   idx;
  logic [IW-1:0] id_q [MAX_OUTST];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          err_q, err_d;
  logic          rdy_q;
  logic          req_any, mreq, push, pop, full, orphan, empty, store;

  // Round-robin search: scan downward so the lowest offset from the pointer wins.
  always_comb begin
    winner = ptr_q;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (bus.req_i[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end

  assign sel     = (state_q == LOCKED) ? win_q : winner;
  assign req_any = (state_q == LOCKED) ? bus.req_i[win_q] : |bus.req_i;
  assign empty   = (cnt_q == '0);
  assign pop     = bus.r_valid_i & ~empty;
  assign full    = (cnt_q == CW'(MAX_OUTST)) & ~pop;
  // rdy_q holds requests off for the first cycle after reset.
  assign mreq    = req_any & ~full & rdy_q & ~rst_i;
  assign push    = mreq & bus.gnt_i;
  assign orphan  = bus.r_valid_i & empty & ~push;
  // A response arriving with an empty FIFO but a same-cycle push bypasses storage.
  assign store   = push & ~(empty & bus.r_valid_i);
  assign head    = empty ? sel : id_q[rd_q];

  assign bus.req_o    = mreq;
  assign bus.add_o    = bus.add_i[sel*AW +: AW];
  assign bus.wen_o    = bus.wen_i[sel];
  assign bus.be_o     = bus.be_i[sel*BW +: BW];
  assign bus.data_o   = bus.data_i[sel*DW +: DW];
  assign bus.r_data_o = bus.r_data_i;
  assign bus.err_o    = err_q;

  always_comb begin
    bus.gnt_o      = '0;
    bus.gnt_o[sel] = push;
    bus.r_valid_o  = '0;
    if (bus.r_valid_i && !orphan) bus.r_valid_o[head] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    err_d   = err_q | orphan;
    ptr_d   = ptr_q;
    if (push) ptr_d = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    case (state_q)
      IDLE: begin
        if (mreq && !bus.gnt_i) begin
          state_d = LOCKED;
          win_d   = winner;
        end
      end
      LOCKED: begin
        if (!bus.req_i[win_q]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (store) wr_q <= (wr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_q + 1'b1;
      if (pop)   rd_q <= (rd_q == PW'(MAX_OUTST - 1)) ? '0 : rd_q + 1'b1;
      cnt_q   <= cnt_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) id_q[wr_q] <= sel;
  end

`ifdef TCDM_ARB_PERF_CNT_EN
  logic [31:0] cnt_gnt_q [N_REQ];
  logic [31:0] cnt_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_REQ; k++) cnt_gnt_q[k] <= '0;
      cnt_stall_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++)
        cnt_gnt_q[k] <= sat_inc(cnt_gnt_q[k], push && (sel == IW'(k)));
      cnt_stall_q <= sat_inc(cnt_stall_q, mreq && !bus.gnt_i);
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) cnt_gnt_o[k*32 +: 32] = cnt_gnt_q[k];
  end
  assign cnt_stall_o = cnt_stall_q;
`endif

endmodule
